// File: rtl/scan_decoder.sv
// scan_decoder: registered N-to-2**N one-hot decoder with direct-select and
// auto-scan modes. In scan mode each index is held for DWELL cycles and a
// one-cycle wrap pulse marks the 2**N-1 -> 0 rollover.
module scan_decoder #(
  parameter int N     = 4,
  parameter int DWELL = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     a,
  input  logic             en,
  input  logic             load,
  input  logic             mode,
  output logic [2**N-1:0]  y,
  output logic [N-1:0]     idx,
  output logic             wrap
);

  localparam int              CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DWELL - 1);

  logic [N-1:0]    idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2**N-1:0] y_q,   y_d;
  logic            wrap_q, wrap_d;

  // Next index/dwell count; y is decoded from idx_d so it tracks idx at the same edge.
  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (!mode) begin
      cnt_d = '0;
      if (load) idx_d = a;
    end else if (load) begin
      idx_d = a;
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        idx_d  = idx_q + N'(1);
        wrap_d = (idx_q == '1);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    y_d = '0;
    if (en) y_d[idx_d] = 1'b1;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q  <= '0;
      cnt_q  <= '0;
      y_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      y_q    <= y_d;
      wrap_q <= wrap_d;
    end
  end

  assign y    = y_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder: default N=4/DWELL=4 instance plus two
// free-running scan instances (N=1/DWELL=1, N=6/DWELL=3).
module tb_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  a;
  logic        en, load, mode;
  logic [15:0] y;
  logic [3:0]  idx;
  logic        wrap;

  logic        rst_s_n;
  logic [1:0]  y1;
  logic [0:0]  idx1;
  logic        wrap1;
  logic [63:0] y6;
  logic [5:0]  idx6;
  logic        wrap6;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned oh_viol  = 0;

  always #5 clk = ~clk;

  scan_decoder #(.N(4), .DWELL(4)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .en(en), .load(load), .mode(mode),
    .y(y), .idx(idx), .wrap(wrap)
  );

  scan_decoder #(.N(1), .DWELL(1)) dut_n1 (
    .clk(clk), .rst_n(rst_s_n), .a(1'b0), .en(1'b1), .load(1'b0), .mode(1'b1),
    .y(y1), .idx(idx1), .wrap(wrap1)
  );

  scan_decoder #(.N(6), .DWELL(3)) dut_n6 (
    .clk(clk), .rst_n(rst_s_n), .a(6'd0), .en(1'b1), .load(1'b0), .mode(1'b1),
    .y(y6), .idx(idx6), .wrap(wrap6)
  );

  always @(negedge clk) begin
    if (!$onehot0(y) || !$onehot0(y1) || !$onehot0(y6)) oh_viol++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [15:0] ey, input logic [3:0] ei,
                      input logic ew);
    chk({tag, ".y"}, 64'(y), 64'(ey));
    chk({tag, ".idx"}, 64'(idx), 64'(ei));
    chk({tag, ".wrap"}, 64'(wrap), 64'(ew));
  endtask

  initial begin
    int unsigned c1, c6, ei;
    rst_n = 1'b0; rst_s_n = 1'b0;
    a = 4'd5; en = 1'b1; load = 1'b1; mode = 1'b1;

    // Reset overrides load/en/mode
    step(); step();
    chk3("reset", 16'h0000, 4'd0, 1'b0);

    // Parameter sweep instances free-run while main DUT is in reset
    rst_s_n = 1'b1;
    c1 = 0; c6 = 0;
    for (int unsigned e = 1; e <= 384; e++) begin
      step();
      if (wrap1) c1++;
      if (wrap6) c6++;
    end
    chk("n1_wraps", 64'(c1), 64'd192);
    chk("n6_wraps", 64'(c6), 64'd2);

    // Direct decode, 1-cycle latency, hold after load drops
    rst_n = 1'b1; mode = 1'b0; en = 1'b1; load = 1'b1; a = 4'd9;
    step();
    chk3("direct_load", 16'h0200, 4'd9, 1'b0);
    load = 1'b0; a = 4'd3;
    step();
    chk3("direct_hold", 16'h0200, 4'd9, 1'b0);

    // en=0 blanks y but load is still honoured
    en = 1'b0; load = 1'b1; a = 4'd7;
    step();
    chk3("direct_en0_load", 16'h0000, 4'd7, 1'b0);
    en = 1'b1; load = 1'b0;
    step();
    chk3("direct_en1", 16'h0080, 4'd7, 1'b0);

    // Scan from reset: index advances every 4 edges, wrap every 64
    rst_n = 1'b0;
    step();
    chk3("scan_rst", 16'h0000, 4'd0, 1'b0);
    rst_n = 1'b1; mode = 1'b1; en = 1'b1; load = 1'b0;
    for (int unsigned e = 1; e <= 150; e++) begin
      step();
      ei = (e / 4) % 16;
      chk3("scan_run", 16'(1 << ei), 4'(ei), (e % 64) == 0);
    end

    // Freeze at idx=5, cnt=2 for 3 cycles, then resume
    en = 1'b0;
    for (int unsigned k = 0; k < 3; k++) begin
      step();
      chk3("freeze", 16'h0000, 4'd5, 1'b0);
    end
    en = 1'b1;
    step();
    chk3("resume1", 16'h0020, 4'd5, 1'b0);
    step();
    chk3("resume2", 16'h0040, 4'd6, 1'b0);

    // Load beats the scheduled 15->0 wrap; cnt restarts at 0
    load = 1'b1; a = 4'd15;
    step();
    chk3("jump15", 16'h8000, 4'd15, 1'b0);
    load = 1'b0;
    step(); step(); step();
    chk3("at15_last", 16'h8000, 4'd15, 1'b0);
    load = 1'b1; a = 4'd3;
    step();
    chk3("jump3", 16'h0008, 4'd3, 1'b0);
    load = 1'b0;
    for (int unsigned k = 0; k < 3; k++) begin
      step();
      chk3("jump3_hold", 16'h0008, 4'd3, 1'b0);
    end
    step();
    chk3("jump3_adv", 16'h0010, 4'd4, 1'b0);

    // Reset mid-scan at idx=11 discards index and dwell count
    load = 1'b1; a = 4'd11;
    step();
    load = 1'b0;
    step(); step();
    chk3("pre_rst11", 16'h0800, 4'd11, 1'b0);
    rst_n = 1'b0;
    step();
    chk3("mid_rst", 16'h0000, 4'd0, 1'b0);
    rst_n = 1'b1;
    for (int unsigned k = 0; k < 3; k++) begin
      step();
      chk3("post_rst_hold", 16'h0001, 4'd0, 1'b0);
    end
    step();
    chk3("post_rst_adv", 16'h0002, 4'd1, 1'b0);

    // Mode 1->0 clears the dwell count; 0->1 restarts a full dwell
    step(); step();
    mode = 1'b0;
    step();
    chk3("mode0", 16'h0002, 4'd1, 1'b0);
    mode = 1'b1;
    for (int unsigned k = 0; k < 3; k++) begin
      step();
      chk3("mode1_hold", 16'h0002, 4'd1, 1'b0);
    end
    step();
    chk3("mode1_adv", 16'h0004, 4'd2, 1'b0);

    chk("onehot0", 64'(oh_viol), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
